// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute control FSM for the 4-bit CPU; optional SINGLE_STEP_EN adds a step port and STEPWAIT parking
module pc_sequencer #(
  parameter int PC_W = 4,
  parameter int OPC_W = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic [OPC_W+PC_W-1:0] instr,
  input  logic                  zero_flag,
  input  logic [PC_W-1:0]       pc_curr,
  output logic                  pc_set,
  output logic [PC_W-1:0]       pc_init,
  output logic                  pc_inc,
  output logic                  a_load,
  output logic                  alu_add,
  output logic [PC_W-1:0]       imm,
  output logic                  halted,
  output logic [2:0]            state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOADVEC = 3'd1, FETCH = 3'd2, DECODE = 3'd3,
    EXEC = 3'd4, HALT = 3'd5, STEPWAIT = 3'd6
  } state_t;
  localparam logic [OPC_W-1:0] LDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] JMP = OPC_W'(3);
  localparam logic [OPC_W-1:0] JZ  = OPC_W'(4);
  localparam logic [OPC_W-1:0] HLT = OPC_W'(5);
  state_t st;
  logic [OPC_W+PC_W-1:0] ir;
  logic jz_taken;
  logic [OPC_W-1:0] op;
  logic [PC_W-1:0] operand;
  logic unused_pc;
  assign op = ir[OPC_W+PC_W-1:PC_W];
  assign operand = ir[PC_W-1:0];
  assign unused_pc = ^pc_curr;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ir <= '0;
      jz_taken <= 1'b0;
    end else begin
      case (st)
        IDLE:     st <= run ? LOADVEC : IDLE;
        LOADVEC:  st <= FETCH;
        FETCH: begin
          ir <= instr;
          st <= DECODE;
        end
        DECODE: begin
          jz_taken <= (op == JZ) && zero_flag;
          st <= EXEC;
        end
`ifdef SINGLE_STEP_EN
        EXEC:     st <= (op == HLT) ? HALT : STEPWAIT;
        STEPWAIT: st <= !run ? IDLE : step ? FETCH : STEPWAIT;
`else
        EXEC:     st <= (op == HLT) ? HALT : run ? FETCH : IDLE;
`endif
        HALT:     st <= HALT;
        default:  st <= IDLE;
      endcase
    end
  end
  // JZ redirect in DECODE looks at the live flag; EXEC uses the latched jz_taken
  always_comb begin
    pc_set  = (st == LOADVEC) || ((st == EXEC) && ((op == JMP) || ((op == JZ) && jz_taken)));
    pc_init = (st == LOADVEC) ? RESET_VEC : operand;
    pc_inc  = (st == DECODE) && !((op == JMP) || (op == HLT) || ((op == JZ) && zero_flag));
    a_load  = (st == EXEC) && ((op == LDI) || (op == ADD));
    alu_add = (st == EXEC) && (op == ADD);
    imm     = operand;
    halted  = (st == HALT);
    state   = st;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests of pc_sequencer against a ROM, PC and A-register environment
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic step = 1'b0;
  logic zero_flag = 1'b0;
  logic [7:0] instr;
  logic [3:0] pc = 4'd0;
  logic [3:0] a = 4'd0;
  logic [7:0] rom [16];
  logic pc_set, pc_inc, a_load, alu_add, halted;
  logic [3:0] pc_init, imm;
  logic [2:0] state;
  logic [15:0] e;
  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr), .zero_flag(zero_flag), .pc_curr(pc),
    .pc_set(pc_set), .pc_init(pc_init), .pc_inc(pc_inc), .a_load(a_load),
    .alu_add(alu_add), .imm(imm), .halted(halted), .state(state)
  );

  assign instr = rom[pc];

  always_ff @(posedge clk) begin
    if (pc_set) pc <= pc_init;
    else if (pc_inc) pc <= pc + 4'd1;
    if (rst) a <= 4'd0;
    else if (a_load) a <= alu_add ? a + imm : imm;
  end

  function automatic logic [15:0] outs();
    return {pc_set, pc_init, pc_inc, a_load, alu_add, imm, halted, state};
  endfunction

  function automatic logic [15:0] pk(bit ps, logic [3:0] pi, bit inc, bit al, bit ad,
                                     logic [3:0] im, bit h, logic [2:0] st);
    return {ps, pi, inc, al, ad, im, h, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    e = pk(0,0,0,0,0,0,0,0); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL reset got %h exp %h", outs(), e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (outs() !== e) begin fails++; $display("FAIL idle_hold%0d got %h exp %h", i, outs(), e); end
    end
  endtask

  task automatic test_program();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h24; rom[2] = 8'h50;
    run = 1'b1;
    tick(); e = pk(1,0,0,0,0,0,0,1); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_loadvec got %h exp %h", outs(), e); end
    tick(); e = pk(0,0,0,0,0,0,0,2); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_fetch0 got %h exp %h", outs(), e); end
    tick(); e = pk(0,3,1,0,0,3,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_dec_ldi got %h exp %h", outs(), e); end
    tick(); e = pk(0,3,0,1,0,3,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_exec_ldi got %h exp %h", outs(), e); end
    tick(); vecs++;
    if (a !== 4'd3 || pc !== 4'd1) begin fails++; $display("FAIL p_a3 got a=%h pc=%h exp a=3 pc=1", a, pc); end
    tick(); e = pk(0,4,1,0,0,4,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_dec_add got %h exp %h", outs(), e); end
    tick(); e = pk(0,4,0,1,1,4,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_exec_add got %h exp %h", outs(), e); end
    tick(); vecs++;
    if (a !== 4'd7 || pc !== 4'd2) begin fails++; $display("FAIL p_a7 got a=%h pc=%h exp a=7 pc=2", a, pc); end
    tick(); e = pk(0,0,0,0,0,0,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_dec_hlt got %h exp %h", outs(), e); end
    tick(); e = pk(0,0,0,0,0,0,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_exec_hlt got %h exp %h", outs(), e); end
    tick(); e = pk(0,0,0,0,0,0,1,5); vecs++;
    if (outs() !== e || pc !== 4'd2) begin fails++; $display("FAIL p_halt got %h pc=%h exp %h pc=2", outs(), pc, e); end
    run = 1'b0; tick(); tick(); run = 1'b1; tick(); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL p_halt_sticky got %h exp %h", outs(), e); end
  endtask

  task automatic test_jmp_wrap();
    do_reset();
    e = pk(0,0,0,0,0,0,0,0); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL j_reset_from_halt got %h exp %h", outs(), e); end
    clear_rom();
    rom[0] = 8'h3F;
    run = 1'b1;
    tick(); tick(); tick(); e = pk(0,15,0,0,0,15,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL j_dec_jmp got %h exp %h", outs(), e); end
    tick(); e = pk(1,15,0,0,0,15,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL j_exec_jmp got %h exp %h", outs(), e); end
    tick(); vecs++;
    if (pc !== 4'd15) begin fails++; $display("FAIL j_pc15 got %h exp f", pc); end
    tick(); e = pk(0,0,1,0,0,0,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL j_dec_nop got %h exp %h", outs(), e); end
    tick(); vecs++;
    if (pc !== 4'd0 || state !== 3'd4) begin fails++; $display("FAIL j_wrap got pc=%h st=%h exp pc=0 st=4", pc, state); end
    run = 1'b0;
    tick(); e = pk(0,0,0,0,0,0,0,0); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL j_stop got %h exp %h", outs(), e); end
  endtask

  task automatic test_jz();
    do_reset();
    clear_rom();
    rom[0] = 8'h48; rom[8] = 8'h48;
    zero_flag = 1'b1;
    run = 1'b1;
    tick(); tick(); tick(); e = pk(0,8,0,0,0,8,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL z_dec_taken got %h exp %h", outs(), e); end
    tick(); zero_flag = 1'b0; e = pk(1,8,0,0,0,8,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL z_exec_taken got %h exp %h", outs(), e); end
    tick(); vecs++;
    if (pc !== 4'd8) begin fails++; $display("FAIL z_pc8 got %h exp 8", pc); end
    tick(); e = pk(0,8,1,0,0,8,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL z_dec_not got %h exp %h", outs(), e); end
    tick(); zero_flag = 1'b1; e = pk(0,8,0,0,0,8,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL z_exec_not got %h exp %h", outs(), e); end
    run = 1'b0;
    tick(); e = pk(0,8,0,0,0,8,0,0); vecs++;
    if (outs() !== e || pc !== 4'd9) begin fails++; $display("FAIL z_idle got %h pc=%h exp %h pc=9", outs(), pc, e); end
    zero_flag = 1'b0;
  endtask

  task automatic test_abort_and_stop();
    do_reset();
    clear_rom();
    rom[0] = 8'h25;
    run = 1'b1;
    tick(); tick(); tick(); tick(); e = pk(0,5,0,1,1,5,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL r_exec_add got %h exp %h", outs(), e); end
    rst = 1'b1;
    tick(); rst = 1'b0; e = pk(0,0,0,0,0,0,0,0); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL r_mid_reset got %h exp %h", outs(), e); end
    tick(); e = pk(1,0,0,0,0,0,0,1); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL r_restart got %h exp %h", outs(), e); end
    tick(); tick(); run = 1'b0; e = pk(0,5,1,0,0,5,0,3); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL r_dec_drop got %h exp %h", outs(), e); end
    tick(); e = pk(0,5,0,1,1,5,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL r_completes got %h exp %h", outs(), e); end
    tick(); tick(); e = pk(0,5,0,0,0,5,0,0); vecs++;
    if (outs() !== e || a !== 4'd5) begin fails++; $display("FAIL r_idle got %h a=%h exp %h a=5", outs(), a, e); end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h12;
    run = 1'b1;
    tick(); tick(); tick(); tick(); e = pk(0,1,0,1,0,1,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL s_exec1 got %h exp %h", outs(), e); end
    tick(); tick(); e = pk(0,1,0,0,0,1,0,6); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL s_parked got %h exp %h", outs(), e); end
    step = 1'b1;
    tick(); step = 1'b0; e = pk(0,1,0,0,0,1,0,2); vecs++;
    if (outs() !== e || pc !== 4'd1) begin fails++; $display("FAIL s_fetch got %h pc=%h exp %h pc=1", outs(), pc, e); end
    tick(); tick(); e = pk(0,2,0,1,0,2,0,4); vecs++;
    if (outs() !== e) begin fails++; $display("FAIL s_exec2 got %h exp %h", outs(), e); end
    tick(); tick(); e = pk(0,2,0,0,0,2,0,6); vecs++;
    if (outs() !== e || a !== 4'd2) begin fails++; $display("FAIL s_parked2 got %h a=%h exp %h a=2", outs(), a, e); end
    run = 1'b0;
    tick(); vecs++;
    if (state !== 3'd0) begin fails++; $display("FAIL s_idle got %h exp 0", state); end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_jmp_wrap();
    test_jz();
    test_abort_and_stop();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
